// File: rtl/cva6_ld_track_pkg.sv
// Shared types for the HPDcache load tracker.
//  ld_size_e       : access size (byte/half/word/dword)
//  ld_entry_t      : one outstanding-load record
//  ld_align_extend : shift a returned 64-bit word down to the accessed bytes,
//                    truncate to the access size and sign- or zero-extend
package cva6_ld_track_pkg;

    localparam int unsigned LD_TRANS_ID_W = 3;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef struct packed {
        logic                     valid;
        logic                     killed;
        logic [LD_TRANS_ID_W-1:0] trans_id;
        logic [2:0]               offset;
        ld_size_e                 size;
        logic                     sign;
    } ld_entry_t;

    function automatic logic [63:0] ld_align_extend(
        input logic [63:0] data,
        input logic [2:0]  offset,
        input ld_size_e    size,
        input logic        sign
    );
        logic [63:0] sh;
        logic [63:0] res;
        sh = data >> {offset, 3'b000};
        case (size)
            LD_B:    res = {{56{sign & sh[7]}},  sh[7:0]};
            LD_H:    res = {{48{sign & sh[15]}}, sh[15:0]};
            LD_W:    res = {{32{sign & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cva6_ld_data_align.sv
// Combinational alignment / extension of a returned 64-bit load word.
//  data_i   : raw word from the cache
//  offset_i : byte offset of the access inside the word
//  size_i   : 0=B 1=H 2=W 3=D
//  sign_i   : 1 = sign-extend, 0 = zero-extend
//  data_o   : aligned, extended result
module cva6_ld_data_align
    import cva6_ld_track_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [63:0] data_o
);

    assign data_o = ld_align_extend(data_i, offset_i, ld_size_e'(size_i), sign_i);

endmodule

// File: rtl/cva6_hpdcache_load_tracker.sv
// Load tracker between the load unit and the HPDcache load port.
// Allocates a cache tid per load (tid = entry index), remembers the scoreboard
// trans_id and the alignment info, and turns cache responses into aligned,
// extended writeback results one cycle later. Killed/flushed loads keep their
// entry until the cache answers, then vanish without a result.
//  clk_i / rst_ni          : clock, async active-low reset
//  flush_i                 : kill all outstanding loads, block new requests
//  ld_req_* / ld_*_i       : load-unit request (valid/ready, trans_id, offset, size, sign)
//  dc_req_valid_o/ready_i  : request to the cache, dc_req_tid_o = allocated tid
//  kill_valid_i/kill_tid_i : kill one outstanding load
//  dc_rsp_*                : cache response (tid, raw 64-bit data)
//  res_*                   : writeback result pulse (trans_id, data)
//  busy_o                  : any entry allocated
//  rsp_err_o               : sticky, a response hit an unallocated tid
module cva6_hpdcache_load_tracker
    import cva6_ld_track_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned TID_W      = 3,
    parameter int unsigned TRANS_ID_W = 3,
    parameter int unsigned XLEN       = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  ld_req_valid_i,
    output logic                  ld_req_ready_o,
    input  logic [TRANS_ID_W-1:0] ld_trans_id_i,
    input  logic [2:0]            ld_offset_i,
    input  logic [1:0]            ld_size_i,
    input  logic                  ld_sign_i,
    output logic                  dc_req_valid_o,
    input  logic                  dc_req_ready_i,
    output logic [TID_W-1:0]      dc_req_tid_o,
    input  logic                  kill_valid_i,
    input  logic [TID_W-1:0]      kill_tid_i,
    input  logic                  dc_rsp_valid_i,
    input  logic [TID_W-1:0]      dc_rsp_tid_i,
    input  logic [XLEN-1:0]       dc_rsp_data_i,
    output logic                  res_valid_o,
    output logic [TRANS_ID_W-1:0] res_trans_id_o,
    output logic [XLEN-1:0]       res_data_o,
    output logic                  busy_o,
    output logic                  rsp_err_o
);

    if ((2 ** TID_W) < NR_ENTRIES) begin : g_tid_chk
        $error("TID_W too narrow for NR_ENTRIES");
    end
    if (XLEN != 64) begin : g_xlen_chk
        $error("only XLEN=64 is supported");
    end
    if (TRANS_ID_W != LD_TRANS_ID_W) begin : g_tr_chk
        $error("TRANS_ID_W must match the package entry layout");
    end

    ld_entry_t ent_q [NR_ENTRIES];
    ld_entry_t ent_d [NR_ENTRIES];

    logic [NR_ENTRIES-1:0] vld_vec;
    logic [NR_ENTRIES-1:0] kill_hit;
    logic [NR_ENTRIES-1:0] rsp_sel;
    logic                  full;
    logic [TID_W-1:0]      alloc_idx;
    logic                  req_hs;
    ld_entry_t             rsp_ent;
    logic                  rsp_hit;
    logic                  rsp_deliver;
    logic [63:0]           rsp_aligned;
    logic                  res_valid_q;
    logic [TRANS_ID_W-1:0] res_trans_id_q;
    logic [XLEN-1:0]       res_data_q;
    logic                  rsp_err_q;

    // Per-entry decode of kill/response tids against the pre-update state.
    always_comb begin
        vld_vec  = '0;
        kill_hit = '0;
        rsp_sel  = '0;
        rsp_ent  = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            vld_vec[i]  = ent_q[i].valid;
            kill_hit[i] = kill_valid_i & (kill_tid_i == TID_W'(i)) & ent_q[i].valid;
            rsp_sel[i]  = (dc_rsp_tid_i == TID_W'(i));
            if (rsp_sel[i]) rsp_ent = ent_q[i];
        end
    end

    // Lowest-index free entry; entries freed this cycle still look busy here.
    always_comb begin
        alloc_idx = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) alloc_idx = TID_W'(i);
        end
    end

    assign full           = &vld_vec;
    assign dc_req_valid_o = ld_req_valid_i & ~full & ~flush_i;
    assign ld_req_ready_o = dc_req_ready_i & ~full & ~flush_i;
    assign dc_req_tid_o   = alloc_idx;
    assign req_hs         = ld_req_valid_i & dc_req_ready_i & ~full & ~flush_i;

    // A kill or flush arriving with the response wins: no result.
    assign rsp_hit     = dc_rsp_valid_i & |(rsp_sel & vld_vec);
    assign rsp_deliver = rsp_hit & ~rsp_ent.killed & ~flush_i
                       & ~(kill_valid_i & (kill_tid_i == dc_rsp_tid_i));

    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid & (flush_i | kill_hit[i])) ent_d[i].killed = 1'b1;
            if (dc_rsp_valid_i & rsp_sel[i] & ent_q[i].valid) begin
                ent_d[i].valid  = 1'b0;
                ent_d[i].killed = 1'b0;
            end
            // Never collides with the free above: alloc only targets free entries.
            if (req_hs && (alloc_idx == TID_W'(i))) begin
                ent_d[i].valid    = 1'b1;
                ent_d[i].killed   = 1'b0;
                ent_d[i].trans_id = ld_trans_id_i;
                ent_d[i].offset   = ld_offset_i;
                ent_d[i].size     = ld_size_e'(ld_size_i);
                ent_d[i].sign     = ld_sign_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) ent_q[i] <= ent_d[i];
        end
    end

    cva6_ld_data_align u_align (
        .data_i   (dc_rsp_data_i),
        .offset_i (rsp_ent.offset),
        .size_i   (rsp_ent.size),
        .sign_i   (rsp_ent.sign),
        .data_o   (rsp_aligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q    <= 1'b0;
            res_trans_id_q <= '0;
            res_data_q     <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            res_valid_q <= rsp_deliver;
            if (rsp_deliver) begin
                res_trans_id_q <= rsp_ent.trans_id;
                res_data_q     <= rsp_aligned;
            end
            if (dc_rsp_valid_i & ~rsp_hit) rsp_err_q <= 1'b1;
        end
    end

    assign res_valid_o    = res_valid_q;
    assign res_trans_id_o = res_trans_id_q;
    assign res_data_o     = res_data_q;
    assign busy_o         = |vld_vec;
    assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_cva6_hpdcache_load_tracker.sv
module tb_cva6_hpdcache_load_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i, ld_req_valid_i, ld_req_ready_o, ld_sign_i;
    logic [2:0]  ld_trans_id_i, ld_offset_i;
    logic [1:0]  ld_size_i;
    logic        dc_req_valid_o, dc_req_ready_i;
    logic [2:0]  dc_req_tid_o;
    logic        kill_valid_i;
    logic [2:0]  kill_tid_i;
    logic        dc_rsp_valid_i;
    logic [2:0]  dc_rsp_tid_i;
    logic [63:0] dc_rsp_data_i;
    logic        res_valid_o;
    logic [2:0]  res_trans_id_o;
    logic [63:0] res_data_o;
    logic        busy_o, rsp_err_o;

    always #5 clk_i = ~clk_i;

    cva6_hpdcache_load_tracker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
        .ld_trans_id_i(ld_trans_id_i), .ld_offset_i(ld_offset_i),
        .ld_size_i(ld_size_i), .ld_sign_i(ld_sign_i),
        .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_req_tid_o(dc_req_tid_o), .kill_valid_i(kill_valid_i),
        .kill_tid_i(kill_tid_i), .dc_rsp_valid_i(dc_rsp_valid_i),
        .dc_rsp_tid_i(dc_rsp_tid_i), .dc_rsp_data_i(dc_rsp_data_i),
        .res_valid_o(res_valid_o), .res_trans_id_o(res_trans_id_o),
        .res_data_o(res_data_o), .busy_o(busy_o), .rsp_err_o(rsp_err_o)
    );

    typedef struct {
        logic        rv, rdy;
        logic [2:0]  tr, off;
        logic [1:0]  sz;
        logic        sg, kv;
        logic [2:0]  kt;
        logic        sv;
        logic [2:0]  st;
        logic [63:0] sd;
        logic        fl;
    } cyc_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  off;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] exp;
    } vec_t;

    // Reference model: what each tid currently holds.
    bit          m_v [8];
    bit          m_k [8];
    logic [2:0]  m_tr [8];
    logic [2:0]  m_off [8];
    logic [1:0]  m_sz [8];
    bit          m_sg [8];
    bit          m_err;

    int checks = 0;
    int failures = 0;
    int last_tid;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-by-byte extraction, then fill upper bytes for sign extension.
    function automatic logic [63:0] ref_align(input logic [63:0] d, input int off,
                                              input int sz, input bit sg);
        int n;
        logic [63:0] r;
        n = 1 << sz;
        r = '0;
        for (int k = 0; k < n; k++)
            if (off + k < 8) r[8*k +: 8] = d[8*(off+k) +: 8];
        if (sg && r[8*n-1])
            for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 0; m_k[i] = 0;
        end
        m_err = 0;
    endtask

    function automatic cyc_t idle_c();
        cyc_t c;
        c = '{default: '0};
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        ld_req_valid_i = c.rv; dc_req_ready_i = c.rdy; ld_trans_id_i = c.tr;
        ld_offset_i = c.off; ld_size_i = c.sz; ld_sign_i = c.sg;
        kill_valid_i = c.kv; kill_tid_i = c.kt; dc_rsp_valid_i = c.sv;
        dc_rsp_tid_i = c.st; dc_rsp_data_i = c.sd; flush_i = c.fl;
    endtask

    // One clock cycle: apply inputs, check combinational outputs against the
    // model, advance the model, then check registered outputs after the edge.
    task automatic cyc(input cyc_t c);
        int free_idx, cnt;
        bit full, hs, deliver, any;
        logic [63:0] exp_d;
        logic [2:0]  exp_tr;
        drive(c);
        #1;
        free_idx = 8;
        for (int i = 7; i >= 0; i--) if (!m_v[i]) free_idx = i;
        full = (free_idx == 8);
        chk("dc_req_valid", dc_req_valid_o, c.rv & !full & !c.fl);
        chk("ld_req_ready", ld_req_ready_o, c.rdy & !full & !c.fl);
        if (c.rv && !full && !c.fl) chk("alloc_tid", dc_req_tid_o, free_idx);
        last_tid = dc_req_tid_o;
        hs = c.rv && c.rdy && !full && !c.fl;
        deliver = c.sv && m_v[c.st] && !m_k[c.st] && !c.fl && !(c.kv && c.kt == c.st);
        exp_d = ref_align(c.sd, m_off[c.st], m_sz[c.st], m_sg[c.st]);
        exp_tr = m_tr[c.st];
        if (c.sv && !m_v[c.st]) m_err = 1;
        for (int i = 0; i < 8; i++) if (m_v[i] && (c.fl || (c.kv && c.kt == i))) m_k[i] = 1;
        if (c.sv && m_v[c.st]) begin m_v[c.st] = 0; m_k[c.st] = 0; end
        if (hs) begin
            m_v[free_idx] = 1; m_k[free_idx] = 0; m_tr[free_idx] = c.tr;
            m_off[free_idx] = c.off; m_sz[free_idx] = c.sz; m_sg[free_idx] = c.sg;
        end
        @(posedge clk_i);
        #1;
        drive(idle_c());
        chk("res_valid", res_valid_o, deliver);
        if (deliver) begin
            chk("res_trans_id", res_trans_id_o, exp_tr);
            chk("res_data", res_data_o, exp_d);
        end
        any = 0; cnt = 0;
        for (int i = 0; i < 8; i++) if (m_v[i]) begin any = 1; cnt++; end
        chk("busy", busy_o, any);
        chk("rsp_err", rsp_err_o, m_err);
    endtask

    task automatic load(input logic [2:0] tr, input logic [2:0] off,
                        input logic [1:0] sz, input logic sg);
        cyc_t c;
        c = idle_c();
        c.rv = 1; c.rdy = 1; c.tr = tr; c.off = off; c.sz = sz; c.sg = sg;
        cyc(c);
    endtask

    task automatic rsp(input logic [2:0] tid, input logic [63:0] d);
        cyc_t c;
        c = idle_c();
        c.sv = 1; c.st = tid; c.sd = d;
        cyc(c);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++)
            if (m_v[i]) rsp(3'(i), {$urandom, $urandom});
        cyc(idle_c());
    endtask

    vec_t vecs [8];

    initial begin
        cyc_t c;
        drive(idle_c());
        m_reset();
        #12;
        chk("reset_res_valid", res_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_rsp_err", rsp_err_o, 0);
        chk("reset_res_trans_id", res_trans_id_o, 0);
        chk("reset_res_data", res_data_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // 1: single sign-extended word load
        load(3'd5, 3'd4, 2'd2, 1'b1);
        chk("t1_tid", last_tid, 0);
        rsp(3'd0, 64'h8000_0001_0000_0000);
        chk("t1_data", res_data_o, 64'hFFFF_FFFF_8000_0001);
        chk("t1_trans_id", res_trans_id_o, 5);
        cyc(idle_c());
        chk("t1_pulse", res_valid_o, 0);

        // Alignment table
        vecs[0] = '{64'h1122334455667788, 3'd0, 2'd0, 1'b0, 64'h0000_0000_0000_0088};
        vecs[1] = '{64'h1122334455667788, 3'd0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[2] = '{64'h1122334455667788, 3'd7, 2'd0, 1'b1, 64'h0000_0000_0000_0011};
        vecs[3] = '{64'h1122334455667788, 3'd2, 2'd1, 1'b0, 64'h0000_0000_0000_5566};
        vecs[4] = '{64'h8001_0000_0000_0000, 3'd6, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        vecs[5] = '{64'hFFFF_FFFF_7FFF_FFFF, 3'd0, 2'd2, 1'b1, 64'h0000_0000_7FFF_FFFF};
        vecs[6] = '{64'hDEAD_BEEF_0000_0000, 3'd4, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[7] = '{64'h8000_0000_0000_0000, 3'd0, 2'd3, 1'b1, 64'h8000_0000_0000_0000};
        for (int v = 0; v < 8; v++) begin
            load(3'(v), vecs[v].off, vecs[v].sz, vecs[v].sg);
            rsp(3'(last_tid), vecs[v].data);
            chk($sformatf("vec%0d_data", v), res_data_o, vecs[v].exp);
        end

        // 2: fill, refuse when full, reuse freed tid only next cycle
        for (int i = 0; i < 8; i++) begin
            load(3'(i), 3'd0, 2'd3, 1'b0);
            chk($sformatf("t2_tid%0d", i), last_tid, i);
        end
        c = idle_c(); c.rv = 1; c.rdy = 1;
        drive(c); #1;
        chk("t2_full_ready", ld_req_ready_o, 0);
        cyc(c);
        c = idle_c(); c.rv = 1; c.rdy = 1; c.sv = 1; c.st = 3; c.sd = 64'h1234;
        cyc(c);
        c = idle_c(); c.rv = 1; c.rdy = 1;
        drive(c); #1;
        chk("t2_ready_after_free", ld_req_ready_o, 1);
        load(3'd1, 3'd0, 2'd3, 1'b0);
        chk("t2_realloc_tid", last_tid, 3);
        drain();

        // 3: kill then response; same-cycle kill and response
        for (int i = 0; i < 3; i++) load(3'(i), 3'd0, 2'd3, 1'b0);
        c = idle_c(); c.kv = 1; c.kt = 2;
        cyc(c);
        rsp(3'd2, 64'hAAAA);
        chk("t3_killed_no_res", res_valid_o, 0);
        for (int i = 0; i < 5; i++) load(3'(i), 3'd0, 2'd3, 1'b0);
        chk("t3_tid6", last_tid, 6);
        c = idle_c(); c.kv = 1; c.kt = 6; c.sv = 1; c.st = 6; c.sd = 64'h55;
        cyc(c);
        chk("t3_kill_rsp_same", res_valid_o, 0);
        drain();

        // 4: flush for two cycles with 4 outstanding
        for (int i = 0; i < 4; i++) load(3'(i), 3'd0, 2'd3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            c = idle_c(); c.rv = 1; c.rdy = 1; c.fl = 1;
            drive(c); #1;
            chk("t4_flush_dc_valid", dc_req_valid_o, 0);
            cyc(c);
        end
        for (int i = 0; i < 4; i++) begin
            rsp(3'(i), 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t4_flushed_no_res", res_valid_o, 0);
        end
        chk("t4_not_busy", busy_o, 0);

        // 5: out-of-order responses, zero extension
        load(3'd4, 3'd3, 2'd0, 1'b0);
        load(3'd2, 3'd6, 2'd1, 1'b0);
        load(3'd7, 3'd0, 2'd3, 1'b0);
        rsp(3'd1, 64'hF0F1_F2F3_F4F5_F6F7);
        chk("t5_order1", res_trans_id_o, 2);
        chk("t5_half", res_data_o, 64'h0000_0000_0000_F0F1);
        rsp(3'd0, 64'hF0F1_F2F3_F4F5_F6F7);
        chk("t5_order0", res_trans_id_o, 4);
        chk("t5_byte", res_data_o, 64'h0000_0000_0000_00F4);
        rsp(3'd2, {$urandom, $urandom});
        chk("t5_order2", res_trans_id_o, 7);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int sz;
            c = idle_c();
            c.rv = $urandom_range(0, 1);
            c.rdy = ($urandom_range(0, 3) != 0);
            sz = $urandom_range(0, 3);
            c.sz = 2'(sz);
            c.off = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
            c.sg = $urandom_range(0, 1);
            c.tr = 3'($urandom_range(0, 7));
            c.kv = ($urandom_range(0, 7) == 0);
            c.kt = 3'($urandom_range(0, 7));
            c.sv = ($urandom_range(0, 2) == 0);
            c.st = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) != 0)
                for (int t = 0; t < 8; t++) begin
                    int j;
                    j = (int'(c.st) + t) % 8;
                    if (m_v[j]) begin c.st = 3'(j); break; end
                end
            c.sd = {$urandom, $urandom};
            c.fl = ($urandom_range(0, 39) == 0);
            cyc(c);
        end
        drain();

        // 6: response to a free tid, sticky error, async reset mid-traffic
        rsp(3'd7, 64'h0);
        chk("t6_err", rsp_err_o, 1);
        cyc(idle_c());
        chk("t6_err_sticky", rsp_err_o, 1);
        load(3'd1, 3'd0, 2'd3, 1'b0);
        load(3'd2, 3'd0, 2'd3, 1'b0);
        rsp(3'd0, 64'h77);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_err", rsp_err_o, 0);
        chk("t6_rst_res_valid", res_valid_o, 0);
        chk("t6_rst_res_data", res_data_o, 0);
        m_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        load(3'd3, 3'd0, 2'd3, 1'b0);
        chk("t6_first_tid", last_tid, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
